// File: rtl/verificador_contador_crescente_decrescente_pkg.sv
// Shared types and helpers for the up/down (bounce) counter checker.
package pkg_contador;

    // Tracking states of the checker.
    typedef enum logic [1:0] {
        VAZIO,
        ESPERA_DIR,
        SUBINDO,
        DESCENDO
    } estado_t;

    // Error counter saturation value (8-bit counter).
    localparam int NUM_ERROS_MAX = 255;

    // Widest sample the step helper accepts; LARGURA must be below this.
    localparam int LARGURA_MAX = 31;

    // Signed step between two samples, computed one bit wider than the
    // samples so that 0 -> MAX is a large positive jump, never a wrap to -1.
    function automatic logic signed [LARGURA_MAX:0] delta_passo(
        input logic [LARGURA_MAX-1:0] anterior,
        input logic [LARGURA_MAX-1:0] atual
    );
        return $signed({1'b0, atual}) - $signed({1'b0, anterior});
    endfunction

endpackage

// File: rtl/verificador_contador_crescente_decrescente.sv
// Monitor for the bounce counter stream: tracks direction, pulses on legal
// turnarounds at the extremes, counts completed cycles and illegal steps.
//
// Handshake: a sample is consumed on a rising clock edge only when valido=1;
// there is no back-pressure, the checker accepts every valid sample. All
// outputs are registered, so the response to a sample appears right after
// the edge that captures it.
module verificador_contador_crescente_decrescente
    import pkg_contador::*;
#(
    parameter int LARGURA        = 4,
    parameter int LARGURA_CICLOS = 8,
    parameter bit PERMITE_PAUSA  = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valido,
    input  logic [LARGURA-1:0]        entrada,
    input  logic                      limpar,
    output logic                      direcao,
    output logic                      direcao_valida,
    output logic                      virada,
    output logic                      erro,
    output logic [7:0]                num_erros,
    output logic [LARGURA_CICLOS-1:0] num_ciclos
);

    localparam logic [LARGURA-1:0]            VALOR_MAX = '1;
    localparam logic [LARGURA-1:0]            VALOR_MIN = '0;
    localparam logic signed [LARGURA_MAX:0]   PASSO_MAIS  = 1;
    localparam logic signed [LARGURA_MAX:0]   PASSO_MENOS = -1;
    localparam logic signed [LARGURA_MAX:0]   PASSO_NULO  = 0;
    localparam logic [7:0]                    ERROS_MAX = 8'(NUM_ERROS_MAX);

    estado_t                     estado, estado_prox;
    logic [LARGURA-1:0]          anterior, anterior_prox;
    logic                        direcao_prox;
    logic                        direcao_valida_prox;
    logic                        virada_prox;
    logic                        erro_prox;
    logic [7:0]                  num_erros_prox;
    logic [LARGURA_CICLOS-1:0]   num_ciclos_prox;
    logic                        erro_detectado;
    logic                        virada_no_zero;
    logic signed [LARGURA_MAX:0] delta;
    logic [7:0]                  erros_base;
    logic [LARGURA_CICLOS-1:0]   ciclos_base;

    // Step of the current sample against the last accepted one.
    always_comb begin
        delta = delta_passo(LARGURA_MAX'(anterior), LARGURA_MAX'(entrada));
    end

    // State register plus all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= VAZIO;
            anterior       <= '0;
            direcao        <= 1'b0;
            direcao_valida <= 1'b0;
            virada         <= 1'b0;
            erro           <= 1'b0;
            num_erros      <= '0;
            num_ciclos     <= '0;
        end else begin
            estado         <= estado_prox;
            anterior       <= anterior_prox;
            direcao        <= direcao_prox;
            direcao_valida <= direcao_valida_prox;
            virada         <= virada_prox;
            erro           <= erro_prox;
            num_erros      <= num_erros_prox;
            num_ciclos     <= num_ciclos_prox;
        end
    end

    // Next-state logic: classify the step against the tracked direction.
    always_comb begin
        estado_prox         = estado;
        anterior_prox       = anterior;
        direcao_prox        = direcao;
        direcao_valida_prox = direcao_valida;
        virada_prox         = 1'b0;
        erro_detectado      = 1'b0;
        virada_no_zero      = 1'b0;

        if (valido) begin
            // Every valid sample becomes the new reference, even a bad one.
            anterior_prox = entrada;
            unique case (estado)
                VAZIO: begin
                    estado_prox = ESPERA_DIR;
                end
                ESPERA_DIR: begin
                    if (delta == PASSO_MAIS) begin
                        estado_prox         = SUBINDO;
                        direcao_prox        = 1'b1;
                        direcao_valida_prox = 1'b1;
                    end else if (delta == PASSO_MENOS) begin
                        estado_prox         = DESCENDO;
                        direcao_prox        = 1'b0;
                        direcao_valida_prox = 1'b1;
                    end else if (delta == PASSO_NULO) begin
                        erro_detectado = !PERMITE_PAUSA;
                    end else begin
                        erro_detectado = 1'b1;
                    end
                end
                SUBINDO: begin
                    if (delta == PASSO_MAIS) begin
                        estado_prox = SUBINDO;
                    end else if (delta == PASSO_MENOS && anterior == VALOR_MAX) begin
                        estado_prox  = DESCENDO;
                        direcao_prox = 1'b0;
                        virada_prox  = 1'b1;
                    end else if (delta == PASSO_NULO) begin
                        erro_detectado = !PERMITE_PAUSA;
                    end else begin
                        erro_detectado = 1'b1;
                    end
                end
                DESCENDO: begin
                    if (delta == PASSO_MENOS) begin
                        estado_prox = DESCENDO;
                    end else if (delta == PASSO_MAIS && anterior == VALOR_MIN) begin
                        estado_prox    = SUBINDO;
                        direcao_prox   = 1'b1;
                        virada_prox    = 1'b1;
                        virada_no_zero = 1'b1;
                    end else if (delta == PASSO_NULO) begin
                        erro_detectado = !PERMITE_PAUSA;
                    end else begin
                        erro_detectado = 1'b1;
                    end
                end
                default: begin
                    estado_prox = VAZIO;
                end
            endcase

            // An illegal step drops the direction and resynchronises.
            if (erro_detectado) begin
                estado_prox         = ESPERA_DIR;
                direcao_valida_prox = 1'b0;
                virada_prox         = 1'b0;
                virada_no_zero      = 1'b0;
            end
        end
    end

    // Counters and sticky flag: limpar clears first, a same-cycle event then counts.
    always_comb begin
        erro_prox   = limpar ? 1'b0 : erro;
        erros_base  = limpar ? '0 : num_erros;
        ciclos_base = limpar ? '0 : num_ciclos;

        num_erros_prox  = erros_base;
        num_ciclos_prox = ciclos_base;

        if (erro_detectado) begin
            erro_prox = 1'b1;
            if (erros_base != ERROS_MAX) begin
                num_erros_prox = erros_base + 8'd1;
            end
        end
        if (virada_no_zero) begin
            num_ciclos_prox = ciclos_base + 1'b1;
        end
    end

endmodule

// File: tb/tb_verificador_contador_crescente_decrescente.sv
// Bench for the bounce-counter checker: two instances (pause illegal / pause
// legal) share one stimulus stream and are compared against a reference
// model that reasons in plain integer steps and a signed direction.
module tb_verificador_contador_crescente_decrescente;

    localparam int LARG = 4;
    localparam int MAXV = (1 << LARG) - 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic            valido  = 1'b0;
    logic [LARG-1:0] entrada = '0;
    logic            limpar  = 1'b0;

    logic       dir0, dv0, vir0, err0;
    logic [7:0] ne0, nc0;
    logic       dir1, dv1, vir1, err1;
    logic [7:0] ne1, nc1;

    verificador_contador_crescente_decrescente #(
        .LARGURA(LARG), .LARGURA_CICLOS(8), .PERMITE_PAUSA(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .valido(valido), .entrada(entrada),
        .limpar(limpar), .direcao(dir0), .direcao_valida(dv0), .virada(vir0),
        .erro(err0), .num_erros(ne0), .num_ciclos(nc0)
    );

    verificador_contador_crescente_decrescente #(
        .LARGURA(LARG), .LARGURA_CICLOS(8), .PERMITE_PAUSA(1'b1)
    ) dut_p (
        .clock(clock), .reset(reset), .valido(valido), .entrada(entrada),
        .limpar(limpar), .direcao(dir1), .direcao_valida(dv1), .virada(vir1),
        .erro(err1), .num_erros(ne1), .num_ciclos(nc1)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, one slot per instance. m_dir: +1 up, -1 down, 0 unknown.
    bit m_tem[2];
    int m_ant[2];
    int m_dir[2];
    int m_vir[2];
    int m_err[2];
    int m_ne[2];
    int m_nc[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_tem[i] = 0; m_ant[i] = 0; m_dir[i] = 0; m_vir[i] = 0;
            m_err[i] = 0; m_ne[i]  = 0; m_nc[i]  = 0;
        end
    endtask

    task automatic model_step(input int i, input bit pausa, input bit v, input int e, input bit l);
        int d;
        bit bad;
        m_vir[i] = 0;
        if (l) begin
            m_err[i] = 0; m_ne[i] = 0; m_nc[i] = 0;
        end
        if (!v) return;
        bad = 0;
        if (!m_tem[i]) begin
            m_tem[i] = 1;
        end else begin
            d = e - m_ant[i];
            if (d == 0) begin
                bad = !pausa;
            end else if (m_dir[i] == 0) begin
                if (d == 1 || d == -1) m_dir[i] = d;
                else bad = 1;
            end else if (d == m_dir[i]) begin
                // continuing in the same direction
            end else if (d == -m_dir[i] && m_ant[i] == ((m_dir[i] > 0) ? MAXV : 0)) begin
                m_dir[i] = -m_dir[i];
                m_vir[i] = 1;
                if (m_dir[i] > 0) m_nc[i] = (m_nc[i] + 1) % 256;
            end else begin
                bad = 1;
            end
        end
        if (bad) begin
            m_err[i] = 1;
            m_ne[i]  = (m_ne[i] < 255) ? m_ne[i] + 1 : 255;
            m_dir[i] = 0;
        end
        m_ant[i] = e;
    endtask

    task automatic compare_all();
        check("p0_dv", dv0, (m_dir[0] != 0) ? 1 : 0);
        if (m_dir[0] != 0) check("p0_dir", dir0, (m_dir[0] > 0) ? 1 : 0);
        check("p0_virada", vir0, m_vir[0]);
        check("p0_erro", err0, m_err[0]);
        check("p0_num_erros", ne0, m_ne[0]);
        check("p0_num_ciclos", nc0, m_nc[0]);
        check("p1_dv", dv1, (m_dir[1] != 0) ? 1 : 0);
        if (m_dir[1] != 0) check("p1_dir", dir1, (m_dir[1] > 0) ? 1 : 0);
        check("p1_virada", vir1, m_vir[1]);
        check("p1_erro", err1, m_err[1]);
        check("p1_num_erros", ne1, m_ne[1]);
        check("p1_num_ciclos", nc1, m_nc[1]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dir"}, dir0, 0);
        check({tag, "_dv"}, dv0, 0);
        check({tag, "_virada"}, vir0, 0);
        check({tag, "_erro"}, err0, 0);
        check({tag, "_num_erros"}, ne0, 0);
        check({tag, "_num_ciclos"}, nc0, 0);
        check({tag, "_p1_erro"}, err1, 0);
        check({tag, "_p1_num_ciclos"}, nc1, 0);
    endtask

    // ---------------- drivers ----------------
    int cnt_vir;

    // Called at a negedge: present inputs, let one rising edge capture them,
    // update the model, then compare at the following negedge.
    task automatic step(input bit v, input int e, input bit l);
        valido  = v;
        entrada = LARG'(e);
        limpar  = l;
        @(posedge clock);
        model_step(0, 1'b0, v, e, l);
        model_step(1, 1'b1, v, e, l);
        @(negedge clock);
        compare_all();
        if (vir0) cnt_vir++;
        if (!v) begin
            check("virada_without_valido_p0", vir0, 0);
            check("virada_without_valido_p1", vir1, 0);
        end
        valido = 1'b0;
        limpar = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        valido = 1'b0; limpar = 1'b0; entrada = '0;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Full bounce 0..15..0 then one step up, optionally interleaving idle cycles.
    task automatic sweep(input bit gaps);
        for (int k = 0; k <= 2 * MAXV + 1; k++) begin
            int val;
            val = (k <= MAXV) ? k : ((k <= 2 * MAXV) ? 2 * MAXV - k : 1);
            step(1'b1, val, 1'b0);
            if (gaps) step(1'b0, (val + 5) % 16, 1'b0);
        end
    endtask

    task automatic run_up_from(input int start, input int stop);
        for (int k = start; k <= stop; k++) step(1'b1, k, 1'b0);
    endtask

    task automatic run_down_from(input int start, input int stop);
        for (int k = start; k >= stop; k--) step(1'b1, k, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cur;
        int gdir;
        int vir_dense;
        int nc_dense;

        model_reset();
        cnt_vir = 0;
        @(negedge clock);
        #1;
        check_zero("reset_initial");
        reset = 1'b1;
        @(negedge clock);

        // Dense legal sweep: two reversals (after 14 and after 1), one cycle.
        cnt_vir = 0;
        sweep(1'b0);
        check("sweep_viradas", cnt_vir, 2);
        check("sweep_num_ciclos", nc0, 1);
        check("sweep_erro", err0, 0);
        vir_dense = cnt_vir;
        nc_dense  = nc0;

        // Two more full cycles (now rising from 1), then an illegal jump.
        for (int r = 0; r < 2; r++) begin
            run_up_from(2, MAXV);
            run_down_from(MAXV - 1, 0);
            step(1'b1, 1, 1'b0);
        end
        check("cycles_three", nc0, 3);
        step(1'b1, 5, 1'b0);
        check("jump_sets_erro", err0, 1);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 7, 1'b0);
        check("first_sample_no_dir", dv0, 0);
        step(1'b1, 8, 1'b0);
        check("second_sample_dv", dv0, 1);
        check("second_sample_dir", dir0, 1);

        // Illegal skip while rising, then resynchronisation.
        do_reset();
        step(1'b1, 3, 1'b0);
        step(1'b1, 4, 1'b0);
        step(1'b1, 5, 1'b0);
        step(1'b1, 9, 1'b0);
        check("skip_erro", err0, 1);
        check("skip_num_erros", ne0, 1);
        check("skip_dv", dv0, 0);
        step(1'b1, 10, 1'b0);
        step(1'b1, 11, 1'b0);
        check("resync_dir", dir0, 1);
        check("resync_dv", dv0, 1);
        check("resync_num_erros", ne0, 1);

        // Boundaries: 14->15 while falling is illegal, 0->15 is illegal.
        do_reset();
        step(1'b1, 15, 1'b0);
        step(1'b1, 14, 1'b0);
        step(1'b1, 15, 1'b0);
        check("rise_while_down_erro", err0, 1);
        do_reset();
        step(1'b1, 1, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 15, 1'b0);
        check("zero_to_max_erro", err0, 1);
        check("zero_to_max_virada", vir0, 0);

        // Repeated sample: an error without pause support, held otherwise.
        do_reset();
        step(1'b1, 5, 1'b0);
        step(1'b1, 6, 1'b0);
        step(1'b1, 6, 1'b0);
        step(1'b1, 6, 1'b0);
        check("pause_p0_num_erros", ne0, 2);
        check("pause_p1_num_erros", ne1, 0);
        check("pause_p1_dv", dv1, 1);
        check("pause_p1_dir", dir1, 1);

        // Saturation of the error count, then limpar together with a new error.
        do_reset();
        for (int k = 0; k < 300; k++) step(1'b1, (k % 2) ? 8 : 0, 1'b0);
        check("saturated_num_erros", ne0, 255);
        step(1'b1, 8, 1'b1);
        check("clear_with_error_erro", err0, 1);
        check("clear_with_error_num_erros", ne0, 1);
        step(1'b0, 0, 1'b1);
        check("clear_alone_erro", err0, 0);

        // Same sweep with valido dropping every other cycle.
        do_reset();
        cnt_vir = 0;
        sweep(1'b1);
        check("gapped_viradas", cnt_vir, vir_dense);
        check("gapped_num_ciclos", nc0, nc_dense);

        // Randomised bounce stream with occasional glitches, pauses and clears.
        do_reset();
        cur  = 0;
        gdir = 1;
        for (int k = 0; k < 1500; k++) begin
            bit v;
            bit l;
            int r;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 59) == 0);
            if (v) begin
                r = $urandom_range(0, 24);
                if (r == 0) begin
                    cur = $urandom_range(0, MAXV);
                end else if (r != 1) begin
                    if (cur == MAXV) gdir = -1;
                    if (cur == 0) gdir = 1;
                    cur = cur + gdir;
                end
            end
            step(v, cur, l);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
